mmio_reg_bank: RTL
==================

// Module: mmio_reg_bank
// PURPOSE
// Parametrised CCI-P MMIO register bank for AFUs: DFH/AFU_ID CSRs plus NUM_REGS 64-bit user
// registers, each read/write (software control) or read-only (hardware status). Sits directly
// behind the registered CCI-P Rx/Tx ports; user logic connects to reg_out/status_in/wr_pulse.
// Configurable read-response latency so decode can be pipelined at larger NUM_REGS.
// PARAMETERS
// NUM_REGS    8           number of user registers, 1..64
// BASE_ADDR   16'h0020    MMIO word address (4-byte units) of user register 0; must be even
// RO_MASK     64'h0       bit i=1: reg i read-only, reads return status_in[i]; writes ignored
// RD_LATENCY  1           cycles from rx.c0.mmioRdValid to tx.c2.mmioRdValid, 1..4
// AFU_ID      128'h0      value returned at AFU_ID_L (16'h0002) / AFU_ID_H (16'h0004)
// PORTS
// clk        in   1              single clock domain
// rst_n      in   1              asynchronous, active-low reset
// rx         in   t_if_ccip_Rx   CCI-P receive; only c0 MMIO fields used
// tx         out  t_if_ccip_Tx   CCI-P transmit; only c2 driven, c0/c1 constant 0
// reg_out    out  NUM_REGS*64    current value of each R/W register (reg i at [64i+63:64i])
// status_in  in   NUM_REGS*64    hardware values for read-only registers
// wr_pulse   out  NUM_REGS       1-cycle strobe, bit i high the cycle after reg i is written
// BEHAVIOUR
// - Reset (rst_n=0, async): reg_out=0, wr_pulse=0, tx='0 (incl. c2.mmioRdValid, hdr, data);
//   read pipeline flushed -- a read in flight at reset produces no response, ever.
// - Decode on mmio_hdr = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr). User reg i at BASE_ADDR+2*i.
// - Writes (rx.c0.mmioWrValid): length must be 8B (2'b01), else ignored. Matching R/W reg
//   loads rx.c0.data[63:0] next edge; wr_pulse[i] high exactly that following cycle. Writes to
//   RO regs, odd addresses, DFH/ID CSRs or unmapped addresses: no state change, no pulse.
// - Reads (rx.c0.mmioRdValid): any length accepted, 64-bit data returned. Data and tid
//   captured in request cycle; tx.c2.mmioRdValid=1 with tx.c2.hdr.tid=request tid exactly
//   RD_LATENCY cycles later, for exactly one cycle. One read per cycle sustained, responses
//   in order, no stalls, no drops.
// - Read map: 16'h0000 DFH {4'b0001,8'b0,4'b0,7'b0,1'b1,24'b0,4'b0,12'b0}; 0002/0004
//   AFU_ID low/high; 0006/0008 zero; user regs as above (R/W: reg_out, RO: status_in
//   sampled in request cycle); everything else incl. odd addresses returns 64'h0.
// - Read in cycle after a write to same reg returns new value (write lands first edge).
// - mmioRdValid and mmioWrValid both high (protocol violation): write performed, read dropped.
// - tx.c2.mmioRdValid low whenever no response due; tx.c2.data holds last value (don't care).
// - Address ranges must not overlap DFH region; BASE_ADDR<16'h000A is a parameter error
//   ($error at elaboration), as are NUM_REGS or RD_LATENCY out of range.
// CONFIGURATION
// MMIO_ACCESS_COUNTER_EN defined: extra R/W-clear register at BASE_ADDR+2*NUM_REGS;
//   [63:32] accepted user-reg writes, [31:0] accepted reads (all addresses); each saturates
//   at all-ones; any 8B write to it clears both (that write not counted); reset clears both.
// Not defined: counter logic absent; that address decodes as unmapped (reads 0, writes ignored).
// TESTING
// 1 Reset, read 16'h0000 -> data 64'h1000_0100_0000_0000, tid echoed, RD_LATENCY cycles later.
// 2 Write 64'hDEAD_BEEF_0123_4567 to 16'h0022 -> reg_out[127:64] updated, wr_pulse=8'b0000_0010
//   for 1 cycle; read 16'h0022 next cycle returns it.
// 3 RO_MASK=64'h4, status_in reg2=64'h55; write 64'hFF to 16'h0024 -> no pulse; read -> 64'h55.
// 4 RD_LATENCY=3, 5 back-to-back reads tids 1..5 -> 5 consecutive responses, tids 1..5 in order.
// 5 Read 16'h0021 and 16'h0100 -> 64'h0; assert rst_n low 1 cycle after a read -> no response.
// 6 With MMIO_ACCESS_COUNTER_EN: 3 writes + 4 reads then read counter -> 64'h0000_0003_0000_0004
//   (that read is counted in subsequent reads only); write clears -> next read 64'h0.

Source files
------------

// File: rtl/mmio_reg_bank.sv
// mmio_reg_bank: CCI-P MMIO register bank with DFH/AFU_ID CSRs and NUM_REGS
// 64-bit user registers. Each register is either read/write (software control)
// or read-only (hardware status). Read responses leave a pipeline that is
// RD_LATENCY stages deep.
// Optional build macro MMIO_ACCESS_COUNTER_EN adds a read/write-clear access
// counter register at BASE_ADDR+2*NUM_REGS.
// ccip_if_pkg below is a minimal subset of the CCI-P interface types. It
// carries only the fields this block touches.

package ccip_if_pkg;
    typedef logic [15:0]  t_ccip_mmioAddr;
    typedef logic [8:0]   t_ccip_tid;
    typedef logic [63:0]  t_ccip_mmioData;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [27:0]  t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd0;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        t_ccip_clData data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module mmio_reg_bank
    import ccip_if_pkg::*;
#(
    parameter int             NUM_REGS   = 8,
    parameter logic [15:0]    BASE_ADDR  = 16'h0020,
    parameter logic [63:0]    RO_MASK    = 64'h0,
    parameter int             RD_LATENCY = 1,
    parameter logic [127:0]   AFU_ID     = 128'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  t_if_ccip_Rx              rx,
    output t_if_ccip_Tx              tx,
    output logic [NUM_REGS*64-1:0]   reg_out,
    input  logic [NUM_REGS*64-1:0]   status_in,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    // AFU feature header: type AFU, end-of-list set, no next DFH.
    localparam logic [63:0] DFH_VALUE = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    // Parameter sanity: the user window must sit clear of the DFH/ID CSRs and fit in 16 bits.
    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_err_num_regs
        $error("mmio_reg_bank: NUM_REGS must be 1..64");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_err_rd_latency
        $error("mmio_reg_bank: RD_LATENCY must be 1..4");
    end
    if (BASE_ADDR < 16'h000A) begin : g_err_base_low
        $error("mmio_reg_bank: BASE_ADDR overlaps the DFH/AFU_ID region");
    end
    if (BASE_ADDR[0]) begin : g_err_base_odd
        $error("mmio_reg_bank: BASE_ADDR must be even");
    end
    if ((int'(BASE_ADDR) + 2*NUM_REGS + 1) > 65535) begin : g_err_base_high
        $error("mmio_reg_bank: register window exceeds the 16-bit MMIO address space");
    end

    function automatic logic [15:0] reg_addr(input int idx);
        return BASE_ADDR + 16'(2*idx);
    endfunction

    t_ccip_c0_ReqMmioHdr     mmio_hdr;
    logic                    wr_ok;
    logic                    rd_ok;
    logic [NUM_REGS-1:0]     wr_hit;
    logic [63:0]             rd_data;
    logic [63:0]             reg_q [NUM_REGS];

    logic                    vld_p  [RD_LATENCY];
    logic [8:0]              tid_p  [RD_LATENCY];
    logic [63:0]             data_p [RD_LATENCY];

`ifdef MMIO_ACCESS_COUNTER_EN
    localparam logic [15:0] CNT_ADDR = BASE_ADDR + 16'(2*NUM_REGS);

    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic        cnt_clr;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction
`endif

    // Request qualification: writes only at 8B length; a read colliding with a write is dropped.
    always_comb begin
        mmio_hdr = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
        wr_ok    = rx.c0.mmioWrValid && (mmio_hdr.length == 2'b01);
        rd_ok    = rx.c0.mmioRdValid && !rx.c0.mmioWrValid;
    end

    // Address decode: read-data mux and per-register write hit.
    always_comb begin
        rd_data = '0;
        wr_hit  = '0;
`ifdef MMIO_ACCESS_COUNTER_EN
        cnt_clr = 1'b0;
`endif
        case (mmio_hdr.address)
            16'h0000: rd_data = DFH_VALUE;
            16'h0002: rd_data = AFU_ID[63:0];
            16'h0004: rd_data = AFU_ID[127:64];
            default:  rd_data = '0;
        endcase
        for (int i = 0; i < NUM_REGS; i++) begin
            if (mmio_hdr.address == reg_addr(i)) begin
                if (RO_MASK[i]) begin
                    rd_data = status_in[64*i +: 64];
                end else begin
                    rd_data   = reg_q[i];
                    wr_hit[i] = wr_ok;
                end
            end
        end
`ifdef MMIO_ACCESS_COUNTER_EN
        if (mmio_hdr.address == CNT_ADDR) begin
            rd_data = {wr_cnt, rd_cnt};
            cnt_clr = wr_ok;
        end
`endif
    end

    // User registers load on a write hit; the strobe follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) reg_q[i] <= rx.c0.data[63:0];
            end
        end
    end

    // Read pipeline: stage 0 captures data/tid in the request cycle; reset flushes all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                vld_p[k]  <= 1'b0;
                tid_p[k]  <= '0;
                data_p[k] <= '0;
            end
        end else begin
            vld_p[0] <= rd_ok;
            if (rd_ok) begin
                tid_p[0]  <= mmio_hdr.tid;
                data_p[0] <= rd_data;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    tid_p[k]  <= tid_p[k-1];
                    data_p[k] <= data_p[k-1];
                end
            end
        end
    end

`ifdef MMIO_ACCESS_COUNTER_EN
    // Access counters: saturating, cleared by any 8B write to the counter address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (cnt_clr) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= sat_inc(wr_cnt, |wr_hit);
            rd_cnt <= sat_inc(rd_cnt, rd_ok);
        end
    end
`endif

    // Transmit: only c2 carries traffic, straight from the last pipeline stage.
    always_comb begin
        tx                = '0;
        tx.c2.mmioRdValid = vld_p[RD_LATENCY-1];
        tx.c2.hdr.tid     = tid_p[RD_LATENCY-1];
        tx.c2.data        = data_p[RD_LATENCY-1];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[64*g +: 64] = reg_q[g];
    end

    // Rx fields this block never looks at; status bits of R/W registers are also unused.
    logic unused_ok;
    assign unused_ok = ^{rx.c0TxAlmFull, rx.c1TxAlmFull, rx.c1, rx.c0.rspValid,
                         rx.c0.data[511:64], mmio_hdr.rsvd0, status_in};

endmodule
